// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// fetch_sequencer_if : instruction-memory bus and instruction-queue packet bus
// Revision: 1.0
// ============================================================================
interface fetch_sequencer_if #(
  parameter int XLEN       = 64,
  parameter int ADDR_WIDTH = 64
);
  logic                  imem_req_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic                  imem_gnt_i;
  logic                  imem_rvalid_i;
  logic [XLEN-1:0]       imem_rdata_i;
  logic                  instr_queue_ready_i;
  logic [XLEN/2-1:0]     inst0_o;
  logic [XLEN/2-1:0]     inst1_o;
  logic                  inst_valid_o;

  modport master (
    output imem_req_o, imem_addr_o, inst0_o, inst1_o, inst_valid_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_queue_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, inst0_o, inst1_o, inst_valid_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_queue_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer : single-outstanding fetch FSM producing instruction pairs
// Revision: 1.0
// ============================================================================
module fetch_sequencer #(
  parameter int                    XLEN       = 64,
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(64'h0000_0000_8000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  ifu_flush_o,
  output logic                  misaligned_exception_o,
  output logic [ADDR_WIDTH-1:0] misaligned_addr_o,
  fetch_sequencer_if.master     bus
);

  localparam int                    HALF       = XLEN / 2;
  localparam logic [HALF-1:0]       NOP        = HALF'(32'h0000_0013);
  localparam logic [ADDR_WIDTH-1:0] STEP_PAIR  = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] STEP_SINGLE = ADDR_WIDTH'(4);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_PUSH = 3'd3,
    S_DROP = 3'd4,
    S_EXC  = 3'd5,
    S_HALT = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [HALF-1:0]       inst0_q, inst0_d;
  logic [HALF-1:0]       inst1_q, inst1_d;
  logic                  valid_q, valid_d;
  logic                  exc_q, exc_d;
  logic [ADDR_WIDTH-1:0] exc_addr_q, exc_addr_d;

  logic aligned;
  logic issue;
  logic outstanding;

  assign aligned = (pc_q[1:0] == 2'b00);
  assign issue   = (state_q == S_REQ) && aligned;

  // A response landing in the redirect cycle is consumed there, so it must not
  // leave the FSM waiting in DROP for a beat that will never come.
  assign outstanding = (((state_q == S_WAIT) || (state_q == S_DROP)) && !bus.imem_rvalid_i)
                     || (issue && bus.imem_gnt_i);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst0_d    = inst0_q;
    inst1_d    = inst1_q;
    valid_d    = valid_q;
    exc_d      = exc_q;
    exc_addr_d = exc_addr_q;

    if (redirect_valid_i) begin
      pc_d    = redirect_pc_i;
      valid_d = 1'b0;
      exc_d   = 1'b0;
      if (outstanding)     state_d = S_DROP;
      else if (fetch_en_i) state_d = S_REQ;
      else                 state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_en_i) state_d = S_REQ;
        end
        S_REQ: begin
          if (!aligned) begin
            exc_d      = 1'b1;
            exc_addr_d = pc_q;
            inst0_d    = '0;
            inst1_d    = '0;
            valid_d    = 1'b1;
            state_d    = S_EXC;
          end else if (bus.imem_gnt_i) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid_i) begin
            // An odd-word PC only owns the upper half of the aligned beat.
            if (!pc_q[2]) begin
              inst0_d = bus.imem_rdata_i[HALF-1:0];
              inst1_d = bus.imem_rdata_i[XLEN-1:HALF];
            end else begin
              inst0_d = bus.imem_rdata_i[XLEN-1:HALF];
              inst1_d = NOP;
            end
            valid_d = 1'b1;
            state_d = S_PUSH;
          end
        end
        S_PUSH: begin
          if (bus.instr_queue_ready_i) begin
            valid_d = 1'b0;
            pc_d    = pc_q + (pc_q[2] ? STEP_SINGLE : STEP_PAIR);
            state_d = fetch_en_i ? S_REQ : S_IDLE;
          end
        end
        S_DROP: begin
          if (bus.imem_rvalid_i) state_d = fetch_en_i ? S_REQ : S_IDLE;
        end
        S_EXC: begin
          if (bus.instr_queue_ready_i) begin
            valid_d = 1'b0;
            exc_d   = 1'b0;
            state_d = S_HALT;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      inst0_q    <= '0;
      inst1_q    <= '0;
      valid_q    <= 1'b0;
      exc_q      <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst0_q    <= inst0_d;
      inst1_q    <= inst1_d;
      valid_q    <= valid_d;
      exc_q      <= exc_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  // The request drops in the redirect cycle itself so a stale fetch never issues.
  assign bus.imem_req_o   = issue && !redirect_valid_i;
  assign bus.imem_addr_o  = issue ? {pc_q[ADDR_WIDTH-1:3], 3'b000} : '0;
  assign bus.inst0_o      = inst0_q;
  assign bus.inst1_o      = inst1_q;
  assign bus.inst_valid_o = valid_q;

  assign ifu_flush_o            = redirect_valid_i;
  assign misaligned_exception_o = exc_q;
  assign misaligned_addr_o      = exc_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer : scoreboard bench for fetch_sequencer
// Revision: 1.0
// ============================================================================
module tb_fetch_sequencer;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [31:0] i0;
    logic [31:0] i1;
    logic        exc;
    logic [63:0] ea;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ifu_flush;
  logic        mis_exc;
  logic [63:0] mis_addr;

  int   n_checks = 0;
  int   n_pass   = 0;
  pkt_t sb[$];

  fetch_sequencer_if #(.XLEN(64), .ADDR_WIDTH(64)) bus ();

  fetch_sequencer #(
    .XLEN(64), .ADDR_WIDTH(64), .RESET_PC(RESET_PC)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .fetch_en_i             (fetch_en),
    .redirect_valid_i       (redirect_valid),
    .redirect_pc_i          (redirect_pc),
    .ifu_flush_o            (ifu_flush),
    .misaligned_exception_o (mis_exc),
    .misaligned_addr_o      (mis_addr),
    .bus                    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full fetch transaction: grant, respond after lat cycles, stall the queue
  // for hold cycles, then accept.
  task automatic do_fetch(input logic [63:0] pc, input logic [63:0] data,
                          input int lat, input int hold, input bit stop_after);
    pkt_t        exp;
    pkt_t        got;
    logic [63:0] exp_addr;
    exp_addr = {pc[63:3], 3'b000};
    for (int i = 0; i < 20 && bus.imem_req_o !== 1'b1; i++) tick();
    n_checks++;
    if (bus.imem_req_o !== 1'b1) begin
      $display("FAIL req_timeout: imem_req_o=%b required 1", bus.imem_req_o);
      return;
    end else n_pass++;
    n_checks++;
    if (bus.imem_addr_o !== exp_addr)
      $display("FAIL req_addr: got %h required %h", bus.imem_addr_o, exp_addr);
    else n_pass++;
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    if (stop_after) fetch_en = 1'b0;
    n_checks++;
    if (bus.imem_req_o !== 1'b0)
      $display("FAIL single_outstanding: imem_req_o=%b required 0", bus.imem_req_o);
    else n_pass++;
    repeat (lat - 1) tick();
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = data;
    exp.exc = 1'b0;
    exp.ea  = '0;
    if (pc[2] == 1'b0) begin
      exp.i0 = data[31:0];
      exp.i1 = data[63:32];
    end else begin
      exp.i0 = data[63:32];
      exp.i1 = 32'h0000_0013;
    end
    sb.push_back(exp);
    tick();
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    n_checks++;
    if (bus.inst_valid_o !== 1'b1) begin
      $display("FAIL valid_latency: inst_valid_o=%b required 1", bus.inst_valid_o);
    end else begin
      n_pass++;
      got = sb.pop_front();
      n_checks++;
      if ({bus.inst0_o, bus.inst1_o} !== {got.i0, got.i1})
        $display("FAIL packet: got %h_%h required %h_%h", bus.inst0_o, bus.inst1_o, got.i0, got.i1);
      else n_pass++;
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      n_checks++;
      if (bus.inst_valid_o !== 1'b1 || bus.inst0_o !== exp.i0 || bus.inst1_o !== exp.i1
          || bus.imem_req_o !== 1'b0)
        $display("FAIL hold_cycle%0d: v=%b i0=%h i1=%h req=%b required v=1 i0=%h i1=%h req=0",
                 h, bus.inst_valid_o, bus.inst0_o, bus.inst1_o, bus.imem_req_o, exp.i0, exp.i1);
      else n_pass++;
    end
    bus.instr_queue_ready_i = 1'b1;
    tick();
    bus.instr_queue_ready_i = 1'b0;
    n_checks++;
    if (bus.inst_valid_o !== 1'b0)
      $display("FAIL valid_after_accept: inst_valid_o=%b required 0", bus.inst_valid_o);
    else n_pass++;
    n_checks++;
    if (bus.imem_req_o !== !stop_after)
      $display("FAIL next_req: imem_req_o=%b required %b", bus.imem_req_o, !stop_after);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i = '0;
    bus.instr_queue_ready_i = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o, bus.inst0_o, bus.inst1_o,
         mis_exc, mis_addr, ifu_flush} !== '0)
      $display("FAIL reset_outputs: req=%b addr=%h v=%b i0=%h i1=%h exc=%b ea=%h flush=%b required all 0",
               bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o, bus.inst0_o, bus.inst1_o,
               mis_exc, mis_addr, ifu_flush);
    else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.imem_req_o !== 1'b0)
      $display("FAIL idle_no_req: imem_req_o=%b required 0", bus.imem_req_o);
    else n_pass++;
  endtask

  task automatic test_basic_fetch();
    fetch_en = 1'b1;
    do_fetch(RESET_PC, 64'hCAFEBABE_DEADBEEF, 2, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_fetch(64'h0000_0000_8000_0008, 64'h1111_2222_3333_4444, 1, 5, 1'b0);
  endtask

  task automatic test_redirect_wait();
    for (int i = 0; i < 20 && bus.imem_req_o !== 1'b1; i++) tick();
    n_checks++;
    if (bus.imem_addr_o !== 64'h0000_0000_8000_0010)
      $display("FAIL rw_addr: got %h required %h", bus.imem_addr_o, 64'h0000_0000_8000_0010);
    else n_pass++;
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h0000_0000_8000_0104;
    #1;
    n_checks++;
    if (ifu_flush !== 1'b1) $display("FAIL flush: ifu_flush_o=%b required 1", ifu_flush);
    else n_pass++;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (bus.imem_req_o !== 1'b0 || bus.inst_valid_o !== 1'b0)
      $display("FAIL drop_state: req=%b v=%b required 0 0", bus.imem_req_o, bus.inst_valid_o);
    else n_pass++;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i = 64'hBAD0BAD0_BAD0BAD0;
    tick();
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i = '0;
    n_checks++;
    if (bus.inst_valid_o !== 1'b0 || sb.size() != 0)
      $display("FAIL stale_dropped: v=%b sb=%0d required 0 0", bus.inst_valid_o, sb.size());
    else n_pass++;
    do_fetch(64'h0000_0000_8000_0104, 64'hAAAA5555_0F0F0F0F, 2, 0, 1'b0);
  endtask

  task automatic test_misaligned();
    pkt_t exp;
    pkt_t got;
    bit   quiet;
    redirect_valid = 1'b1;
    redirect_pc = 64'h0000_0000_8000_0002;
    #1;
    n_checks++;
    if (bus.imem_req_o !== 1'b0)
      $display("FAIL withdraw: imem_req_o=%b required 0", bus.imem_req_o);
    else n_pass++;
    exp = '{i0: 32'h0, i1: 32'h0, exc: 1'b1, ea: 64'h0000_0000_8000_0002};
    sb.push_back(exp);
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (bus.imem_req_o !== 1'b0)
      $display("FAIL misaligned_no_req: imem_req_o=%b required 0", bus.imem_req_o);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.inst_valid_o !== 1'b1) begin
      $display("FAIL exc_valid: inst_valid_o=%b required 1", bus.inst_valid_o);
    end else begin
      n_pass++;
      got = sb.pop_front();
      n_checks++;
      if ({mis_exc, mis_addr, bus.inst0_o, bus.inst1_o} !== {got.exc, got.ea, got.i0, got.i1})
        $display("FAIL exc_packet: exc=%b ea=%h i0=%h i1=%h required exc=%b ea=%h i0=%h i1=%h",
                 mis_exc, mis_addr, bus.inst0_o, bus.inst1_o, got.exc, got.ea, got.i0, got.i1);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (bus.inst_valid_o !== 1'b1 || mis_exc !== 1'b1)
      $display("FAIL exc_hold: v=%b exc=%b required 1 1", bus.inst_valid_o, mis_exc);
    else n_pass++;
    bus.instr_queue_ready_i = 1'b1;
    tick();
    bus.instr_queue_ready_i = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.imem_req_o !== 1'b0 || bus.inst_valid_o !== 1'b0 || mis_exc !== 1'b0) quiet = 1'b0;
      tick();
    end
    n_checks++;
    if (quiet !== 1'b1)
      $display("FAIL halt_quiet: activity seen in HALT, quiet=%b required 1", quiet);
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc = RESET_PC;
    tick();
    redirect_valid = 1'b0;
    do_fetch(RESET_PC, 64'h0123_4567_89AB_CDEF, 1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 20 && bus.imem_req_o !== 1'b1; i++) tick();
    bus.imem_gnt_i = 1'b1;
    tick();
    bus.imem_gnt_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o, bus.inst0_o, bus.inst1_o,
         mis_exc, mis_addr} !== '0)
      $display("FAIL async_reset: req=%b addr=%h v=%b i0=%h i1=%h exc=%b ea=%h required all 0",
               bus.imem_req_o, bus.imem_addr_o, bus.inst_valid_o, bus.inst0_o, bus.inst1_o,
               mis_exc, mis_addr);
    else n_pass++;
    fetch_en = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i = '0;
    n_checks++;
    if (bus.inst_valid_o !== 1'b0 || bus.imem_req_o !== 1'b0)
      $display("FAIL late_rvalid: v=%b req=%b required 0 0", bus.inst_valid_o, bus.imem_req_o);
    else n_pass++;
    fetch_en = 1'b1;
    do_fetch(RESET_PC, 64'h5A5A_5A5A_A5A5_A5A5, 3, 0, 1'b0);
  endtask

  task automatic test_wrap_and_stop();
    bit quiet;
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    do_fetch(64'hFFFF_FFFF_FFFF_FFF8, 64'h7777_8888_9999_AAAA, 1, 0, 1'b0);
    do_fetch(64'h0, 64'h0000_0013_0000_0093, 2, 1, 1'b1);
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.imem_req_o !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (quiet !== 1'b1)
      $display("FAIL stop_idle: request seen after fetch disabled, quiet=%b required 1", quiet);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_wait();
    test_misaligned();
    test_reset_mid_wait();
    test_wrap_and_stop();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_empty: %0d left required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
